// File: rtl/pay_settle_pkg.sv
// rtl/pay_settle_pkg.sv - shared states, denomination codes and code-to-value decode for pay_settle
//
// Contents:
//   ST_*        settlement FSM state encodings (2-bit)
//   CODE_*      denomination codes presented on the paid input
//   code_value  maps a denomination code to its face value (0 for codes 0 and 7)
package pay_settle_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_COLLECT = 2'd1;
    localparam state_t ST_DONE    = 2'd2;
    localparam state_t ST_FAIL    = 2'd3;

    localparam logic [2:0] CODE_NONE = 3'd0;
    localparam logic [2:0] CODE_1    = 3'd1;
    localparam logic [2:0] CODE_2    = 3'd2;
    localparam logic [2:0] CODE_5    = 3'd3;
    localparam logic [2:0] CODE_10   = 3'd4;
    localparam logic [2:0] CODE_20   = 3'd5;
    localparam logic [2:0] CODE_50   = 3'd6;

    function automatic logic [7:0] code_value(input logic [2:0] code);
        logic [7:0] v;
        case (code)
            CODE_1:  v = 8'd1;
            CODE_2:  v = 8'd2;
            CODE_5:  v = 8'd5;
            CODE_10: v = 8'd10;
            CODE_20: v = 8'd20;
            CODE_50: v = 8'd50;
            CODE_NONE: v = 8'd0;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/pay_timeout.sv
// rtl/pay_timeout.sv - idle-cycle counter that flags expiry after TIMEOUT_CYC cycles
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   clear_i   forces the count back to zero (takes priority over enable_i)
//   enable_i  counts one cycle per clock while high
//   expire_o  high while enabled and the count has reached TIMEOUT_CYC-1
module pay_timeout #(
    parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            // Parks at LAST so the counter can never wrap back to a quiet value.
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/pay_settle.sv
// rtl/pay_settle.sv - payment session settlement: accumulate coins, finish on price met or abort
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   enterpay    session request level; a rising level starts a session
//   paid        denomination code (0 = nothing); a change to codes 1..6 is one insert
//   price       amount due, latched at session start
//   cancel      user abort level
//   busy        high while collecting
//   paid_total  saturating sum accepted this session (held after the session)
//   change      amount returned at session end (held after the session)
//   pay_done    one-cycle pulse when the price was met
//   pay_fail    one-cycle pulse on cancel, enterpay drop or timeout
import pay_settle_pkg::*;

module pay_settle #(
    parameter int unsigned TIMEOUT_CYC = 500_000_000,
    parameter int unsigned AMT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enterpay,
    input  logic [2:0]       paid,
    input  logic [AMT_W-1:0] price,
    input  logic             cancel,
    output logic             busy,
    output logic [AMT_W-1:0] paid_total,
    output logic [AMT_W-1:0] change,
    output logic             pay_done,
    output logic             pay_fail
);

    state_t           state_q, state_d;
    logic [2:0]       paid_q;
    logic             ep_q;
    logic [AMT_W-1:0] price_q, price_d;
    logic [AMT_W-1:0] total_q, total_d;
    logic [AMT_W-1:0] change_q, change_d;

    logic             insert;
    logic             start;
    logic             expire;
    logic             abort;
    logic [AMT_W:0]   sum_wide;
    logic [AMT_W-1:0] sum_sat;

    // A held code is a single insert; only a transition onto a real denomination counts.
    assign insert = (paid != paid_q) && (paid >= CODE_1) && (paid <= CODE_50);
    assign start  = enterpay && !ep_q;

    assign sum_wide = {1'b0, total_q}
                    + (insert ? (AMT_W+1)'(code_value(paid)) : '0);
    assign sum_sat  = sum_wide[AMT_W] ? '1 : sum_wide[AMT_W-1:0];

    assign abort = cancel || !enterpay || expire;

    // Counter sits at zero outside COLLECT so every session starts with a full window.
    pay_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  ((state_q != ST_COLLECT) || insert),
        .enable_i (state_q == ST_COLLECT),
        .expire_o (expire)
    );

    always_comb begin
        state_d  = state_q;
        price_d  = price_q;
        total_d  = total_q;
        change_d = change_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    price_d  = price;
                    total_d  = '0;
                    change_d = '0;
                    state_d  = (price == '0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                total_d = sum_sat;
                // Abort outranks completion; a coin arriving with the abort is refunded.
                if (abort) begin
                    change_d = sum_sat;
                    state_d  = ST_FAIL;
                end else if (sum_sat >= price_q) begin
                    change_d = sum_sat - price_q;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            paid_q   <= '0;
            ep_q     <= 1'b0;
            price_q  <= '0;
            total_q  <= '0;
            change_q <= '0;
        end else begin
            state_q  <= state_d;
            paid_q   <= paid;
            ep_q     <= enterpay;
            price_q  <= price_d;
            total_q  <= total_d;
            change_q <= change_d;
        end
    end

    assign busy       = (state_q == ST_COLLECT);
    assign pay_done   = (state_q == ST_DONE);
    assign pay_fail   = (state_q == ST_FAIL);
    assign paid_total = total_q;
    assign change     = change_q;

endmodule
